wfq_count_update: RTL and testbench
===================================

// Module: wfq_count_update
// PURPOSE
//  Read-modify-write engine for per-flow packet counters held in block_ram_count.
//  Accepts one inc/dec/clear/read request per cycle, issues the RAM read, applies the op with
//  saturation, and writes back. Includes a write-to-read bypass for back-to-back hits on one flow.
//  Clears every RAM entry after reset. Sits between the WFQ classifier/scheduler and the count RAM.
// PARAMETERS
//  N     13   flow-ID / RAM address width; RAM depth 2**N
//  W     N-5  count width (localparam, = block_ram_count data width)
// PORTS
//  clk          in   1    system clock
//  rst          in   1    synchronous active-high reset
//  req_valid    in   1    request present
//  req_ready    out  1    engine accepts request (high only in RUN)
//  req_flow     in   N    flow ID
//  req_op       in   2    00 read, 01 inc, 10 dec, 11 clear
//  resp_valid   out  1    response strobe
//  resp_flow    out  N    flow ID of response
//  resp_count   out  W    count after op is applied
//  resp_sat     out  1    inc at max or dec at 0 (value held)
//  init_done    out  1    high once the post-reset clear sweep finishes
//  ram_we       out  1    to block_ram_count we
//  ram_w_addr   out  N    to block_ram_count w_addr
//  ram_r_addr   out  N    to block_ram_count r_addr
//  ram_din      out  W    to block_ram_count din
//  ram_dout     in   W    from block_ram_count dout (registered, 1-cycle read latency)
// BEHAVIOUR
//  Reset: state=INIT, sweep ptr=0, resp_valid=0, resp_flow=0, resp_count=0, resp_sat=0,
//   init_done=0, req_ready=0, S1 valid=0, bypass valid=0. Reset mid-sweep or mid-op drops in-flight op; sweep restarts at 0.
//  FSM INIT: ram_we=1, ram_w_addr=ptr, ram_din=0, ptr++ each cycle; at ptr=2**N-1 -> RUN.
//   Sweep takes exactly 2**N cycles. init_done rises on the first RUN cycle.
//  FSM RUN: req_ready=1 continuously; accept when req_valid&req_ready (cycle t).
//   ram_r_addr = req_flow combinationally in cycle t. Flow/op registered into S1.
//  S1 (cycle t+1): old = (byp_vld && byp_addr==S1.flow) ? byp_data : ram_dout.
//   inc: old==2**W-1 ? old, sat=1 : old+1.   dec: old==0 ? 0, sat=1 : old-1.
//   clear: 0.   read: old, no write.
//   inc/dec/clear: ram_we=1, ram_w_addr=S1.flow, ram_din=new, combinational in t+1.
//  Response: resp_valid/flow/count/sat registered from S1; valid at t+2. resp_valid is high 1 cycle per op.
//  Bypass reg: on every S1 write, byp_vld<=1, byp_addr<=flow, byp_data<=new. On read op, left unchanged.
//   Needed because a read issued in the same cycle as a write to that address returns the old value.
//   Deeper hazards need no bypass: the RAM holds the value from 2+ cycles back.
//  Throughput 1 op/cycle in RUN. No backpressure on resp.
//  Width rule: all count arithmetic is W bits; no wrap ever occurs (saturating).
//  When ram_we=0, ram_w_addr and ram_din are don't-care. ram_r_addr=0 when idle.
// TESTING (sim with N=6, W=1 not allowed -> use N=8, W=3)
//  T1 reset, then hold: ram_we high for 256 cycles at addrs 0..255 with din=0; init_done on cycle 257.
//  T2 inc flow 5 on 3 consecutive cycles -> resp_count 1,2,3 (bypass exercised); RAM[5]=3.
//  T3 inc 5, inc 9, inc 5 back-to-back -> counts 4,1,5 for T2 state (RAM path at distance 2).
//  T4 dec flow 7 at 0 -> resp_count 0, sat=1, RAM[7] stays 0. Then 8 incs -> last count 7 with sat=1.
//  T5 clear flow 5 then read 5 next cycle -> 0 and 0; read op asserts no ram_we.
//  T6 assert rst mid-sweep (ptr=100) and mid-RUN burst -> no resp_valid, sweep restarts from 0, full 256 cycles.

Source files
------------

// File: rtl/wfq_count_update.sv
// Read-modify-write engine for per-flow packet counters.
// After reset, every count RAM entry is cleared. The engine then accepts one
// read/inc/dec/clear request per cycle and applies saturating arithmetic.
// Results are written back to the RAM, and a one-entry bypass covers a
// read-during-write hazard between back-to-back ops on the same flow.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_INIT | clear sweep: write 0 to one RAM address per cycle, no requests
// ST_RUN  | accept requests, one op per cycle through the S1 stage
module wfq_count_update #(
    parameter  int N = 13,
    localparam int W = N - 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_flow,
    input  logic [1:0]   req_op,
    output logic         resp_valid,
    output logic [N-1:0] resp_flow,
    output logic [W-1:0] resp_count,
    output logic         resp_sat,
    output logic         init_done,
    output logic         ram_we,
    output logic [N-1:0] ram_w_addr,
    output logic [N-1:0] ram_r_addr,
    output logic [W-1:0] ram_din,
    input  logic [W-1:0] ram_dout
);

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] ptr_q, ptr_d;

    logic         s1_vld_q;
    logic [N-1:0] s1_flow_q;
    logic [1:0]   s1_op_q;

    logic         byp_vld_q;
    logic [N-1:0] byp_addr_q;
    logic [W-1:0] byp_data_q;

    logic         resp_valid_q;
    logic [N-1:0] resp_flow_q;
    logic [W-1:0] resp_count_q;
    logic         resp_sat_q;

    logic         accept;
    logic [W-1:0] old_cnt;
    logic [W-1:0] new_cnt;
    logic         s1_sat;
    logic         s1_wr;

    // Requests are refused while reset is asserted, even though the state register still says RUN.
    assign req_ready  = (state_q == ST_RUN) && !rst;
    assign init_done  = (state_q == ST_RUN) && !rst;
    assign accept     = req_valid && req_ready;
    assign ram_r_addr = accept ? req_flow : '0;

    assign resp_valid = resp_valid_q;
    assign resp_flow  = resp_flow_q;
    assign resp_count = resp_count_q;
    assign resp_sat   = resp_sat_q;

    // State register and sweep pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic: the sweep walks every address once, then moves to RUN.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + N'(1);
                if (ptr_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // S1 modify step: pick the freshest old value, then apply the op with saturation.
    always_comb begin
        old_cnt = (byp_vld_q && (byp_addr_q == s1_flow_q)) ? byp_data_q : ram_dout;
        new_cnt = old_cnt;
        s1_sat  = 1'b0;
        s1_wr   = 1'b0;
        case (s1_op_q)
            OP_INC: begin
                s1_wr = 1'b1;
                if (old_cnt == '1) begin
                    s1_sat = 1'b1;
                end else begin
                    new_cnt = old_cnt + W'(1);
                end
            end
            OP_DEC: begin
                s1_wr = 1'b1;
                if (old_cnt == '0) begin
                    s1_sat = 1'b1;
                end else begin
                    new_cnt = old_cnt - W'(1);
                end
            end
            OP_CLR: begin
                s1_wr   = 1'b1;
                new_cnt = '0;
            end
            default: begin
                s1_wr = 1'b0;
            end
        endcase
        s1_wr = s1_wr && s1_vld_q;
    end

    // RAM write port: the sweep owns it in INIT, S1 writeback owns it in RUN.
    always_comb begin
        ram_we     = 1'b0;
        ram_w_addr = '0;
        ram_din    = '0;
        if (state_q == ST_INIT) begin
            ram_we     = 1'b1;
            ram_w_addr = ptr_q;
        end else begin
            ram_we     = s1_wr && !rst;
            ram_w_addr = s1_flow_q;
            ram_din    = new_cnt;
        end
    end

    // Pipeline, bypass, and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q     <= 1'b0;
            s1_flow_q    <= '0;
            s1_op_q      <= OP_READ;
            byp_vld_q    <= 1'b0;
            byp_addr_q   <= '0;
            byp_data_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_flow_q  <= '0;
            resp_count_q <= '0;
            resp_sat_q   <= 1'b0;
        end else begin
            s1_vld_q     <= accept;
            if (accept) begin
                s1_flow_q <= req_flow;
                s1_op_q   <= req_op;
            end
            if (s1_wr) begin
                byp_vld_q  <= 1'b1;
                byp_addr_q <= s1_flow_q;
                byp_data_q <= new_cnt;
            end
            resp_valid_q <= s1_vld_q;
            if (s1_vld_q) begin
                resp_flow_q  <= s1_flow_q;
                resp_count_q <= new_cnt;
                resp_sat_q   <= s1_sat;
            end
        end
    end

endmodule

// File: tb/tb_wfq_count_update.sv
// Directed bench for wfq_count_update with N=8 (W=3).
// A behavioural count RAM with registered read and old-data-on-collision sits beside the DUT.
module tb_wfq_count_update;

    localparam int N = 8;
    localparam int W = 3;
    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [N-1:0] req_flow = '0;
    logic [1:0]   req_op = OP_READ;
    logic         resp_valid;
    logic [N-1:0] resp_flow;
    logic [W-1:0] resp_count;
    logic         resp_sat;
    logic         init_done;
    logic         ram_we;
    logic [N-1:0] ram_w_addr;
    logic [N-1:0] ram_r_addr;
    logic [W-1:0] ram_din;
    logic [W-1:0] ram_dout;

    logic [W-1:0] mem [0:(2**N)-1];

    int errors = 0;
    int checks = 0;

    wfq_count_update #(.N(N)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_flow(req_flow), .req_op(req_op), .resp_valid(resp_valid),
        .resp_flow(resp_flow), .resp_count(resp_count), .resp_sat(resp_sat),
        .init_done(init_done), .ram_we(ram_we), .ram_w_addr(ram_w_addr),
        .ram_r_addr(ram_r_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_w_addr] <= ram_din;
        ram_dout <= mem[ram_r_addr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_count !== '0 || resp_flow !== '0 || resp_sat !== 1'b0 ||
            init_done !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset: valid=%b flow=%0d count=%0d sat=%b init_done=%b ready=%b, want all 0",
                     resp_valid, resp_flow, resp_count, resp_sat, init_done, req_ready);
        end
    endtask

    // Releases reset and follows the full clear sweep until RUN.
    task automatic test_init_sweep;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2**N; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (ram_we !== 1'b1 || ram_w_addr !== N'(i) || ram_din !== '0 || init_done !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL sweep cycle %0d: we=%b addr=%0d din=%0d init_done=%b ready=%b, want we=1 addr=%0d din=0 init_done=0 ready=0",
                         i, ram_we, ram_w_addr, ram_din, init_done, req_ready, i);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (init_done !== 1'b1 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL init_done: init_done=%b ready=%b, want 1 1", init_done, req_ready);
        end
    endtask

    task automatic test_bypass;
        logic [N-1:0] fl [3];
        logic [W-1:0] ec [3];
        fl = '{8'd5, 8'd5, 8'd5};
        ec = '{3'd1, 3'd2, 3'd3};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c < 3) begin
                req_valid = 1'b1; req_flow = fl[c]; req_op = OP_INC;
            end else begin
                req_valid = 1'b0;
            end
            #1;
            if (c >= 2) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_flow !== fl[c-2] || resp_count !== ec[c-2] || resp_sat !== 1'b0) begin
                    errors++;
                    $display("FAIL bypass op%0d: valid=%b flow=%0d count=%0d sat=%b, want 1 %0d %0d 0",
                             c-2, resp_valid, resp_flow, resp_count, resp_sat, fl[c-2], ec[c-2]);
                end
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0 || mem[5] !== 3'd3 || ram_r_addr !== '0) begin
            errors++;
            $display("FAIL bypass end: valid=%b ram5=%0d r_addr=%0d, want 0 3 0", resp_valid, mem[5], ram_r_addr);
        end
    endtask

    task automatic test_distance2;
        logic [N-1:0] fl [3];
        logic [W-1:0] ec [3];
        fl = '{8'd5, 8'd9, 8'd5};
        ec = '{3'd4, 3'd1, 3'd5};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c < 3) begin
                req_valid = 1'b1; req_flow = fl[c]; req_op = OP_INC;
            end else begin
                req_valid = 1'b0;
            end
            #1;
            if (c < 3) begin
                checks++;
                if (ram_r_addr !== fl[c]) begin
                    errors++;
                    $display("FAIL dist2 r_addr op%0d: got %0d want %0d", c, ram_r_addr, fl[c]);
                end
            end
            if (c >= 2) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_flow !== fl[c-2] || resp_count !== ec[c-2] || resp_sat !== 1'b0) begin
                    errors++;
                    $display("FAIL dist2 op%0d: valid=%b flow=%0d count=%0d sat=%b, want 1 %0d %0d 0",
                             c-2, resp_valid, resp_flow, resp_count, resp_sat, fl[c-2], ec[c-2]);
                end
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (mem[5] !== 3'd5 || mem[9] !== 3'd1) begin
            errors++;
            $display("FAIL dist2 ram: ram5=%0d ram9=%0d, want 5 1", mem[5], mem[9]);
        end
    endtask

    task automatic test_saturation;
        logic [1:0]   op [9];
        logic [W-1:0] ec [9];
        logic         es [9];
        op = '{OP_DEC, OP_INC, OP_INC, OP_INC, OP_INC, OP_INC, OP_INC, OP_INC, OP_INC};
        ec = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7};
        es = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (c < 9) begin
                req_valid = 1'b1; req_flow = 8'd7; req_op = op[c];
            end else begin
                req_valid = 1'b0;
            end
            #1;
            if (c == 2) begin
                checks++;
                if (mem[7] !== 3'd0) begin
                    errors++;
                    $display("FAIL sat dec ram7: got %0d want 0", mem[7]);
                end
            end
            if (c >= 2) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_flow !== 8'd7 || resp_count !== ec[c-2] || resp_sat !== es[c-2]) begin
                    errors++;
                    $display("FAIL sat op%0d: valid=%b flow=%0d count=%0d sat=%b, want 1 7 %0d %b",
                             c-2, resp_valid, resp_flow, resp_count, resp_sat, ec[c-2], es[c-2]);
                end
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (mem[7] !== 3'd7 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL sat end: ram7=%0d valid=%b, want 7 0", mem[7], resp_valid);
        end
    endtask

    task automatic test_clear_read;
        logic [1:0] op [2];
        op = '{OP_CLR, OP_READ};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c < 2) begin
                req_valid = 1'b1; req_flow = 8'd5; req_op = op[c];
            end else begin
                req_valid = 1'b0;
            end
            #1;
            if (c == 1) begin
                checks++;
                if (ram_we !== 1'b1 || ram_w_addr !== 8'd5 || ram_din !== 3'd0) begin
                    errors++;
                    $display("FAIL clear write: we=%b addr=%0d din=%0d, want 1 5 0", ram_we, ram_w_addr, ram_din);
                end
            end
            if (c == 2) begin
                checks++;
                if (ram_we !== 1'b0) begin
                    errors++;
                    $display("FAIL read no-write: we=%b want 0", ram_we);
                end
            end
            if (c >= 2) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_flow !== 8'd5 || resp_count !== 3'd0 || resp_sat !== 1'b0) begin
                    errors++;
                    $display("FAIL clear/read op%0d: valid=%b flow=%0d count=%0d sat=%b, want 1 5 0 0",
                             c-2, resp_valid, resp_flow, resp_count, resp_sat);
                end
            end
        end
    endtask

    task automatic test_reset_midway;
        bit found = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_flow = 8'd3; req_op = OP_INC;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (resp_valid !== 1'b0 || init_done !== 1'b0) begin
                errors++;
                $display("FAIL run reset cycle %0d: valid=%b init_done=%b, want 0 0", c, resp_valid, init_done);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            #1;
            if (ram_w_addr === 8'd100 && ram_we === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL sweep ptr 100: not reached within 300 cycles, addr=%0d", ram_w_addr);
        end
        rst = 1'b1;
        test_init_sweep();
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL after restart: valid=%b want 0", resp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_bypass();
        test_distance2();
        test_saturation();
        test_clear_read();
        test_reset_midway();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
